// File: rtl/cv32e40p_x_dispatch_if.sv
// X-interface bundle between the core, the dispatcher and the coprocessor cluster.
// The slave modport is the dispatcher's view; the master modport is the surrounding environment's view.
interface cv32e40p_x_dispatch_if #(
  parameter int NUM_COPROC = 2,
  parameter int DEPTH      = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  // core side
  logic                         x_valid_i;
  logic                         x_ready_o;
  logic [31:0]                  x_instr_data_i;
  logic [2:0][31:0]             x_rs_i;
  logic [2:0]                   x_rs_valid_i;
  logic                         x_accept_o;
  logic                         x_is_mem_op_o;
  logic                         x_writeback_o;
  logic                         x_rvalid_o;
  logic                         x_rready_i;
  logic [4:0]                   x_rd_o;
  logic [31:0]                  x_data_o;
  logic                         x_dualwb_o;
  logic                         x_type_o;
  logic                         x_error_o;

  // coprocessor side
  logic [NUM_COPROC-1:0]        cp_valid_o;
  logic [NUM_COPROC-1:0]        cp_ready_i;
  logic [NUM_COPROC-1:0]        cp_accept_i;
  logic [NUM_COPROC-1:0]        cp_is_mem_op_i;
  logic [NUM_COPROC-1:0]        cp_writeback_i;
  logic [31:0]                  cp_instr_data_o;
  logic [2:0][31:0]             cp_rs_o;
  logic [2:0]                   cp_rs_valid_o;
  logic [NUM_COPROC-1:0]        cp_rvalid_i;
  logic [NUM_COPROC-1:0]        cp_rready_o;
  logic [NUM_COPROC-1:0][4:0]   cp_rd_i;
  logic [NUM_COPROC-1:0][31:0]  cp_data_i;
  logic [NUM_COPROC-1:0]        cp_dualwb_i;
  logic [NUM_COPROC-1:0]        cp_type_i;
  logic [NUM_COPROC-1:0]        cp_error_i;

  logic [CW-1:0]                outstanding_o;

  modport slave (
    input  x_valid_i, x_instr_data_i, x_rs_i, x_rs_valid_i, x_rready_i,
    output x_ready_o, x_accept_o, x_is_mem_op_o, x_writeback_o,
    output x_rvalid_o, x_rd_o, x_data_o, x_dualwb_o, x_type_o, x_error_o,
    output cp_valid_o, cp_instr_data_o, cp_rs_o, cp_rs_valid_o, cp_rready_o,
    input  cp_ready_i, cp_accept_i, cp_is_mem_op_i, cp_writeback_i,
    input  cp_rvalid_i, cp_rd_i, cp_data_i, cp_dualwb_i, cp_type_i, cp_error_i,
    output outstanding_o
  );

  modport master (
    output x_valid_i, x_instr_data_i, x_rs_i, x_rs_valid_i, x_rready_i,
    input  x_ready_o, x_accept_o, x_is_mem_op_o, x_writeback_o,
    input  x_rvalid_o, x_rd_o, x_data_o, x_dualwb_o, x_type_o, x_error_o,
    input  cp_valid_o, cp_instr_data_o, cp_rs_o, cp_rs_valid_o, cp_rready_o,
    output cp_ready_i, cp_accept_i, cp_is_mem_op_i, cp_writeback_i,
    output cp_rvalid_i, cp_rd_i, cp_data_i, cp_dualwb_i, cp_type_i, cp_error_i,
    input  outstanding_o
  );
endinterface

// File: rtl/cv32e40p_x_dispatch.sv
// Broadcasts X-interface offloads to NUM_COPROC coprocessors and returns responses in offload order.
// Optional response watchdog enabled by defining CV32E40P_X_TIMEOUT_EN.
module cv32e40p_x_dispatch #(
  parameter int NUM_COPROC     = 2,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  cv32e40p_x_dispatch_if.slave   xif
);

  localparam int IW = (NUM_COPROC > 1) ? $clog2(NUM_COPROC) : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  if (NUM_COPROC < 1 || NUM_COPROC > 8) begin : g_bad_num
    $error("NUM_COPROC must be in 1..8");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $error("DEPTH must be at least 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [NUM_COPROC-1:0] done_q, acc_q, wb_q, mem_q;
  logic [NUM_COPROC-1:0] dead;
  logic [NUM_COPROC-1:0] cp_valid, hs, cp_done;
  logic [NUM_COPROC-1:0] eff_acc, eff_wb, eff_mem;
  logic [NUM_COPROC-1:0] rready;

  logic [IW-1:0] fifo_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;

  logic          full, nonempty, base_valid, req_ready;
  logic          any_acc, push, pop, rvalid, timed_out;
  logic [IW-1:0] winner, head;

  assign xif.cp_instr_data_o = xif.x_instr_data_i;
  assign xif.cp_rs_o         = xif.x_rs_i;
  assign xif.cp_rs_valid_o   = xif.x_rs_valid_i;

  assign full       = (count_q == CW'(DEPTH));
  assign nonempty   = (count_q != '0);
  // a pop in the same cycle does not release a full FIFO for the request
  assign base_valid = xif.x_valid_i & ~full;

  assign cp_valid = {NUM_COPROC{base_valid}} & ~done_q & ~dead;
  assign hs       = cp_valid & xif.cp_ready_i;
  assign cp_done  = done_q | dead | xif.cp_ready_i;
  assign req_ready = base_valid & (&cp_done);

  assign xif.cp_valid_o = cp_valid;
  assign xif.x_ready_o  = req_ready;

  // latched answers from earlier cycles merge with answers handshaking now
  assign eff_acc = ((done_q & acc_q) | (hs & xif.cp_accept_i)) & ~dead;
  assign eff_wb  = (done_q & wb_q)  | (hs & xif.cp_writeback_i);
  assign eff_mem = (done_q & mem_q) | (hs & xif.cp_is_mem_op_i);

  always_comb begin
    winner  = '0;
    any_acc = |eff_acc;
    for (int i = NUM_COPROC - 1; i >= 0; i--) begin
      if (eff_acc[i]) winner = IW'(i);
    end
  end

  assign xif.x_accept_o    = req_ready & any_acc;
  assign xif.x_writeback_o = req_ready & any_acc & eff_wb[winner];
  assign xif.x_is_mem_op_o = req_ready & any_acc & eff_mem[winner];

  assign push = req_ready & any_acc & eff_wb[winner];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q <= '0;
      acc_q  <= '0;
      wb_q   <= '0;
      mem_q  <= '0;
    end else if (req_ready || !xif.x_valid_i) begin
      done_q <= '0;
      acc_q  <= '0;
      wb_q   <= '0;
      mem_q  <= '0;
    end else begin
      done_q <= done_q | hs;
      acc_q  <= acc_q | (hs & xif.cp_accept_i);
      wb_q   <= wb_q  | (hs & xif.cp_writeback_i);
      mem_q  <= mem_q | (hs & xif.cp_is_mem_op_i);
    end
  end

  assign head = fifo_q[rptr_q];

`ifdef CV32E40P_X_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0]         tmo_q;
  logic [NUM_COPROC-1:0] dead_q;

  assign timed_out = nonempty & (tmo_q == TW'(TIMEOUT_CYCLES));
  assign dead      = dead_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_q  <= '0;
      dead_q <= '0;
    end else begin
      if (!nonempty || pop) begin
        tmo_q <= '0;
      end else if (!timed_out) begin
        tmo_q <= tmo_q + TW'(1);
      end
      // dead coprocessors stay excluded until the next reset
      if (pop && timed_out) begin
        dead_q[head] <= 1'b1;
      end
    end
  end
`else
  assign timed_out = 1'b0;
  assign dead      = '0;
`endif

  assign rvalid = nonempty & (timed_out | xif.cp_rvalid_i[head]);
  assign pop    = rvalid & xif.x_rready_i;

  assign xif.x_rvalid_o = rvalid;
  assign xif.x_rd_o     = timed_out ? 5'd0  : xif.cp_rd_i[head];
  assign xif.x_data_o   = timed_out ? 32'd0 : xif.cp_data_i[head];
  assign xif.x_dualwb_o = ~timed_out & xif.cp_dualwb_i[head];
  assign xif.x_type_o   = ~timed_out & xif.cp_type_i[head];
  assign xif.x_error_o  = timed_out | xif.cp_error_i[head];

  // only the head may hand back a result; dead units are drained silently
  always_comb begin
    rready = dead;
    if (nonempty && !timed_out && xif.x_rready_i) begin
      rready[head] = 1'b1;
    end
  end
  assign xif.cp_rready_o = rready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        fifo_q[wptr_q] <= winner;
        wptr_q <= (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_q <= (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign xif.outstanding_o = count_q;

endmodule

// File: tb/tb_cv32e40p_x_dispatch.sv
// Directed bench for cv32e40p_x_dispatch with a queue-based reference model checked every cycle.
module tb_cv32e40p_x_dispatch;
  localparam int N = 2;
  localparam int D = 4;
  localparam int T = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cv32e40p_x_dispatch_if #(.NUM_COPROC(N), .DEPTH(D)) xif ();

  cv32e40p_x_dispatch #(.NUM_COPROC(N), .DEPTH(D), .TIMEOUT_CYCLES(T)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .xif   (xif)
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: queue of owning coprocessors and the set already answering the current request
  int     q[$];
  bit     served[N];
  bit     s_acc[N], s_wb[N], s_mem[N];
  logic [N-1:0] e_cpv, e_rr;
  logic   e_full, e_all, e_rdy, e_any, e_w, e_m, e_acc, e_wbo, e_mem, e_rv, a;
  int     e_win, h;

  always @(negedge clk) begin
    if (chk_en) begin
      e_full = (q.size() == D);
      e_all  = 1'b1;
      for (int i = 0; i < N; i++) begin
        e_cpv[i] = xif.x_valid_i & !e_full & !served[i];
        e_all    = e_all & (served[i] | xif.cp_ready_i[i]);
      end
      e_rdy = xif.x_valid_i & !e_full & e_all;
      e_any = 1'b0; e_win = 0; e_w = 1'b0; e_m = 1'b0;
      for (int i = 0; i < N; i++) begin
        a = served[i] ? s_acc[i] : (e_cpv[i] & xif.cp_ready_i[i] & xif.cp_accept_i[i]);
        if (a && !e_any) begin
          e_any = 1'b1;
          e_win = i;
          e_w   = served[i] ? s_wb[i]  : xif.cp_writeback_i[i];
          e_m   = served[i] ? s_mem[i] : xif.cp_is_mem_op_i[i];
        end
      end
      e_acc = e_rdy & e_any;
      e_wbo = e_acc & e_w;
      e_mem = e_acc & e_m;
      e_rv  = 1'b0;
      e_rr  = '0;
      if (q.size() != 0) begin
        h = q[0];
        e_rv = xif.cp_rvalid_i[h];
        e_rr[h] = xif.x_rready_i;
      end
      chk("cp_valid", xif.cp_valid_o, e_cpv);
      chk("x_ready", xif.x_ready_o, e_rdy);
      chk("x_accept", xif.x_accept_o, e_acc);
      chk("x_writeback", xif.x_writeback_o, e_wbo);
      chk("x_is_mem_op", xif.x_is_mem_op_o, e_mem);
      chk("x_rvalid", xif.x_rvalid_o, e_rv);
      chk("cp_rready", xif.cp_rready_o, e_rr);
      chk("outstanding", xif.outstanding_o, q.size());
      if (e_rv) begin
        chk("x_rd", xif.x_rd_o, xif.cp_rd_i[h]);
        chk("x_data", xif.x_data_o, xif.cp_data_i[h]);
        chk("x_dualwb", xif.x_dualwb_o, xif.cp_dualwb_i[h]);
        chk("x_type", xif.x_type_o, xif.cp_type_i[h]);
        chk("x_error", xif.x_error_o, xif.cp_error_i[h]);
      end
      if (e_rv && xif.x_rready_i) void'(q.pop_front());
      if (e_wbo) q.push_back(e_win);
      for (int i = 0; i < N; i++) begin
        if (e_rdy || !xif.x_valid_i) begin
          served[i] = 1'b0; s_acc[i] = 1'b0; s_wb[i] = 1'b0; s_mem[i] = 1'b0;
        end else if (e_cpv[i] && xif.cp_ready_i[i]) begin
          served[i] = 1'b1;
          s_acc[i]  = xif.cp_accept_i[i];
          s_wb[i]   = xif.cp_writeback_i[i];
          s_mem[i]  = xif.cp_is_mem_op_i[i];
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    xif.x_valid_i      = 1'b0;
    xif.x_instr_data_i = '0;
    xif.x_rs_i         = '0;
    xif.x_rs_valid_i   = '0;
    xif.x_rready_i     = 1'b0;
    xif.cp_ready_i     = '0;
    xif.cp_accept_i    = '0;
    xif.cp_is_mem_op_i = '0;
    xif.cp_writeback_i = '0;
    xif.cp_rvalid_i    = '0;
    xif.cp_rd_i        = '0;
    xif.cp_data_i      = '0;
    xif.cp_dualwb_i    = '0;
    xif.cp_type_i      = '0;
    xif.cp_error_i     = '0;
  endtask

  task automatic offer(input logic [N-1:0] rdy, input logic [N-1:0] acc, input logic [N-1:0] wb);
    xif.x_valid_i      = 1'b1;
    xif.cp_ready_i     = rdy;
    xif.cp_accept_i    = acc;
    xif.cp_writeback_i = wb;
  endtask

  initial begin
    int n;
    for (int i = 0; i < N; i++) begin
      served[i] = 1'b0; s_acc[i] = 1'b0; s_wb[i] = 1'b0; s_mem[i] = 1'b0;
    end
    idle();
    #12;
    chk("rst_x_rvalid", xif.x_rvalid_o, 1'b0);
    chk("rst_cp_rready", xif.cp_rready_o, 2'b00);
    chk("rst_outstanding", xif.outstanding_o, 0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    settle();
    chk("idle_cp_valid", xif.cp_valid_o, 2'b00);

    // single offload, zero-latency completion
    offer(2'b11, 2'b10, 2'b10);
    xif.x_instr_data_i = 32'h1234_5678;
    xif.x_rs_i[1]      = 32'hDEAD_BEEF;
    xif.x_rs_valid_i   = 3'b011;
    settle();
    chk("t1_ready", xif.x_ready_o, 1'b1);
    chk("t1_accept", xif.x_accept_o, 1'b1);
    chk("t1_wb", xif.x_writeback_o, 1'b1);
    chk("t1_instr", xif.cp_instr_data_o, 32'h1234_5678);
    chk("t1_rs1", xif.cp_rs_o[1], 32'hDEAD_BEEF);
    chk("t1_rsv", xif.cp_rs_valid_o, 3'b011);
    cyc(); idle(); settle();
    chk("t1_out1", xif.outstanding_o, 1);
    xif.cp_rvalid_i  = 2'b10;
    xif.cp_rd_i[1]   = 5'd5;
    xif.cp_data_i[1] = 32'hCAFE_0001;
    xif.x_rready_i   = 1'b1;
    settle();
    chk("t1_rvalid", xif.x_rvalid_o, 1'b1);
    chk("t1_rd", xif.x_rd_o, 5'd5);
    chk("t1_data", xif.x_data_o, 32'hCAFE_0001);
    chk("t1_rready", xif.cp_rready_o, 2'b10);
    cyc(); idle(); settle();
    chk("t1_out0", xif.outstanding_o, 0);

    // staggered ready, winner from latched cp0
    offer(2'b01, 2'b01, 2'b01);
    settle();
    chk("t2_cpv0", xif.cp_valid_o, 2'b11);
    chk("t2_ready0", xif.x_ready_o, 1'b0);
    cyc();
    offer(2'b00, 2'b00, 2'b00);
    settle();
    chk("t2_cpv1", xif.cp_valid_o, 2'b10);
    cyc(); cyc();
    offer(2'b10, 2'b00, 2'b00);
    settle();
    chk("t2_ready3", xif.x_ready_o, 1'b1);
    chk("t2_accept3", xif.x_accept_o, 1'b1);
    chk("t2_wb3", xif.x_writeback_o, 1'b1);
    cyc(); idle();

    // reordering: A on cp0 is pending, B goes to cp1 and answers first
    offer(2'b11, 2'b10, 2'b10);
    settle();
    chk("t3_ready_b", xif.x_ready_o, 1'b1);
    cyc(); idle();
    xif.cp_rvalid_i  = 2'b10;
    xif.cp_rd_i[1]   = 5'd7;
    xif.cp_data_i[1] = 32'hBBBB_0002;
    xif.x_rready_i   = 1'b1;
    settle();
    chk("t3_hold_rvalid", xif.x_rvalid_o, 1'b0);
    chk("t3_hold_rready", xif.cp_rready_o, 2'b01);
    cyc();
    cyc();
    xif.cp_rvalid_i  = 2'b11;
    xif.cp_rd_i[0]   = 5'd3;
    xif.cp_data_i[0] = 32'hAAAA_0001;
    settle();
    chk("t3_a_rd", xif.x_rd_o, 5'd3);
    chk("t3_a_data", xif.x_data_o, 32'hAAAA_0001);
    cyc(); settle();
    chk("t3_b_rvalid", xif.x_rvalid_o, 1'b1);
    chk("t3_b_rd", xif.x_rd_o, 5'd7);
    chk("t3_b_rready", xif.cp_rready_o, 2'b10);
    cyc(); idle(); settle();
    chk("t3_out0", xif.outstanding_o, 0);

    // full at DEPTH
    offer(2'b11, 2'b01, 2'b01);
    xif.cp_is_mem_op_i = 2'b01;
    settle();
    chk("t4_mem", xif.x_is_mem_op_o, 1'b1);
    for (int k = 0; k < 4; k++) cyc();
    settle();
    chk("t4_full_ready", xif.x_ready_o, 1'b0);
    chk("t4_full_cpv", xif.cp_valid_o, 2'b00);
    chk("t4_full_out", xif.outstanding_o, 4);
    xif.cp_rvalid_i = 2'b01;
    xif.x_rready_i  = 1'b1;
    settle();
    chk("t4_pop_stall", xif.x_ready_o, 1'b0);
    cyc();
    xif.cp_rvalid_i = 2'b00;
    settle();
    chk("t4_fifth", xif.x_ready_o, 1'b1);
    cyc();
    xif.x_valid_i = 1'b0;
    settle();
    chk("t4_out4", xif.outstanding_o, 4);
    xif.cp_rvalid_i = 2'b01;
    for (int k = 0; k < 4; k++) cyc();
    idle(); settle();
    chk("t4_out0", xif.outstanding_o, 0);

    // push and pop together at count 1
    offer(2'b11, 2'b01, 2'b01);
    cyc();
    offer(2'b11, 2'b10, 2'b10);
    xif.cp_rvalid_i = 2'b01;
    xif.x_rready_i  = 1'b1;
    settle();
    chk("t5_ready", xif.x_ready_o, 1'b1);
    chk("t5_rvalid", xif.x_rvalid_o, 1'b1);
    cyc(); idle(); settle();
    chk("t5_out1", xif.outstanding_o, 1);
    xif.cp_rvalid_i  = 2'b10;
    xif.cp_rd_i[1]   = 5'd9;
    xif.cp_data_i[1] = 32'h0000_0099;
    xif.cp_error_i   = 2'b10;
    xif.x_rready_i   = 1'b1;
    settle();
    chk("t5_head_rd", xif.x_rd_o, 5'd9);
    chk("t5_head_err", xif.x_error_o, 1'b1);
    cyc(); idle(); settle();
    chk("t5_out0", xif.outstanding_o, 0);

    // no accept, then accept without writeback
    offer(2'b11, 2'b00, 2'b11);
    settle();
    chk("t6_ready", xif.x_ready_o, 1'b1);
    chk("t6_noacc", xif.x_accept_o, 1'b0);
    chk("t6_nowb", xif.x_writeback_o, 1'b0);
    cyc();
    offer(2'b11, 2'b01, 2'b00);
    settle();
    chk("t6_acc", xif.x_accept_o, 1'b1);
    chk("t6_wb0", xif.x_writeback_o, 1'b0);
    cyc(); idle(); settle();
    chk("t6_out0", xif.outstanding_o, 0);

    // abort clears the done mask
    offer(2'b01, 2'b01, 2'b01);
    cyc();
    idle();
    cyc();
    offer(2'b00, 2'b01, 2'b01);
    settle();
    chk("t7_cpv", xif.cp_valid_o, 2'b11);
    cyc();
    offer(2'b11, 2'b01, 2'b01);
    cyc(); idle();
    xif.cp_rvalid_i = 2'b01;
    xif.cp_dualwb_i = 2'b01;
    xif.cp_type_i   = 2'b01;
    xif.x_rready_i  = 1'b1;
    settle();
    chk("t7_dualwb", xif.x_dualwb_o, 1'b1);
    chk("t7_type", xif.x_type_o, 1'b1);
    cyc(); idle(); settle();
    chk("t7_out0", xif.outstanding_o, 0);

`ifdef CV32E40P_X_TIMEOUT_EN
    chk_en = 1'b0;
    offer(2'b11, 2'b01, 2'b01);
    cyc(); idle(); settle();
    n = 0;
    while (!xif.x_rvalid_o && n < 50) begin
      cyc();
      n++;
    end
    chk("t8_tmo_cycles", n, T);
    chk("t8_error", xif.x_error_o, 1'b1);
    chk("t8_rd", xif.x_rd_o, 5'd0);
    chk("t8_data", xif.x_data_o, 32'd0);
    xif.x_rready_i = 1'b1;
    settle();
    chk("t8_no_rready", xif.cp_rready_o, 2'b00);
    cyc(); idle(); settle();
    chk("t8_out0", xif.outstanding_o, 0);
    chk("t8_drain", xif.cp_rready_o, 2'b01);
    offer(2'b10, 2'b10, 2'b00);
    settle();
    chk("t8_cpv", xif.cp_valid_o, 2'b10);
    chk("t8_ready", xif.x_ready_o, 1'b1);
    chk("t8_accept", xif.x_accept_o, 1'b1);
    cyc(); idle();
    xif.cp_rvalid_i = 2'b01;
    settle();
    chk("t8_late_rready", xif.cp_rready_o, 2'b01);
    chk("t8_late_rvalid", xif.x_rvalid_o, 1'b0);
    cyc(); idle();
`else
    n = 0;
`endif

    cyc();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
